// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one synchronous write port,
// optional write-through bypass, optional hardwired-zero r0 and a pending-write scoreboard.
module reg_file_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] a1_i,
    input  logic [ADDR_W-1:0] a2_i,
    output logic [WIDTH-1:0]  rd1_o,
    output logic [WIDTH-1:0]  rd2_o,
    input  logic [ADDR_W-1:0] a3_i,
    input  logic              we3_i,
    input  logic [WIDTH-1:0]  wd3_i,
    input  logic              issue_en_i,
    input  logic [ADDR_W-1:0] issue_a_i,
    output logic              busy1_o,
    output logic              busy2_o,
    output logic              any_busy_o
);
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0] pending_q, pending_d;
    logic             wr_en;

    logic [1:0][ADDR_W-1:0] ra;
    logic [1:0][WIDTH-1:0]  rd;
    logic [1:0]             busy;

    assign wr_en = we3_i && !(ZERO_REG && (a3_i == '0));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[a3_i] <= wd3_i;
        end
    end

    // Issue is applied after writeback clear so a newer producer keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (we3_i)      pending_d[a3_i]      = 1'b0;
        if (issue_en_i) pending_d[issue_a_i] = 1'b1;
        if (ZERO_REG)   pending_d[0]         = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign ra = {a2_i, a1_i};

    for (genvar p = 0; p < 2; p++) begin : g_rport
        logic hit, zero;
        assign hit  = BYPASS && we3_i && (a3_i == ra[p]);
        assign zero = ZERO_REG && (ra[p] == '0);

        always_comb begin
            rd[p] = regs_q[ra[p]];
            if (zero)     rd[p] = '0;
            else if (hit) rd[p] = wd3_i;
        end

        assign busy[p] = pending_q[ra[p]] & ~hit;
    end

    assign rd1_o      = rd[0];
    assign rd2_o      = rd[1];
    assign busy1_o    = busy[0];
    assign busy2_o    = busy[1];
    assign any_busy_o = |pending_q;
endmodule
